// File: rtl/mem_access_unit.sv
// mem_access_unit -- memory stage of the 5-stage pipeline.
//
// Runs loads and stores on a req/ack data bus and stalls the pipeline until
// the access finishes. Handles byte/half/word sizing, little-endian lane
// steering, load sign/zero extension and a bus timeout.
//
// Build option: define MEM_ALIGN_CHK_EN to reject misaligned half/word
// accesses. A rejected access skips the bus, pulses align_err for one cycle
// and returns 0 for loads. Without the macro, the low address bits only
// select the lane, and align_err is held at 0.
//
// Parameter:
//   TIMEOUT      WAIT cycles without mem_ack before the access is aborted
//                (0 = never abort)
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   MemRdtoMe    load request
//   MemWrtoMe    store request (wins if both requests are high)
//   MemSize      00 byte, 01 half, 1x word
//   LdSigned     1 = sign-extend sub-word loads
//   ALUouttoMe   effective byte address
//   busBtoMe     store data
//   stall        freezes the earlier pipeline stages while high
//   MenouttoMen  extended load data sent to MEM/WB
//   mem_*        bus request, write enable, word address, byte enables,
//                write data, read data, ack strobe
//   bus_err      sticky timeout flag (cleared only by rst)
//   align_err    one-cycle misalignment pulse
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRdtoMe,
  input  logic        MemWrtoMe,
  input  logic [1:0]  MemSize,
  input  logic        LdSigned,
  input  logic [31:0] ALUouttoMe,
  input  logic [31:0] busBtoMe,
  output logic        stall,
  output logic [31:0] MenouttoMen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   menout_q, menout_d;
  logic          bus_err_q, bus_err_d;
  logic          align_err_q, align_err_d;

  logic        op;
  logic        is_store;
  logic [1:0]  a_lo;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign op       = MemRdtoMe | MemWrtoMe;
  assign is_store = MemWrtoMe;
  assign a_lo     = ALUouttoMe[1:0];

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = (MemSize == 2'b01 && a_lo[0]) || (MemSize[1] && a_lo != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Byte enables and lane-replicated write data for the incoming request.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = busBtoMe;
    if (!MemSize[1]) begin
      if (MemSize[0]) begin
        be_new    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{busBtoMe[15:0]}};
      end else begin
        be_new    = 4'b0001 << a_lo;
        wdata_new = {4{busBtoMe[7:0]}};
      end
    end
  end

  // Load extraction uses the latched size/sign/lane so the pipeline inputs
  // are free to change while the access is in flight.
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (size_q[1]) begin
      load_val = mem_rdata;
    end else if (size_q[0]) begin
      load_val = {{16{signed_q & rd_half[15]}}, rd_half};
    end else begin
      load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    menout_d    = menout_q;
    bus_err_d   = bus_err_q;
    align_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            state_d     = DONE;
            align_err_d = 1'b1;
            if (!is_store) menout_d = 32'd0;
          end else begin
            state_d     = WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {ALUouttoMe[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            size_d      = MemSize;
            signed_d    = LdSigned;
            lane_d      = a_lo;
            cnt_d       = '0;
          end
        end
      end
      WAIT: begin
        // An ack on the last allowed cycle still completes normally.
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) menout_d = load_val;
        end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          menout_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      lane_q      <= 2'd0;
      cnt_q       <= '0;
      menout_q    <= 32'd0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      menout_q    <= menout_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign stall       = (state_q == IDLE && op) || (state_q == WAIT);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign MenouttoMen = menout_q;
  assign bus_err     = bus_err_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It runs directed accesses and then random
// accesses, and checks every result against a reference model inside the bench.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRdtoMe, MemWrtoMe;
  logic [1:0]  MemSize;
  logic        LdSigned;
  logic [31:0] ALUouttoMe, busBtoMe;
  logic        stall;
  logic [31:0] MenouttoMen;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err, align_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_out = 32'd0;
  logic        model_berr = 1'b0;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemRdtoMe(MemRdtoMe), .MemWrtoMe(MemWrtoMe),
    .MemSize(MemSize), .LdSigned(LdSigned),
    .ALUouttoMe(ALUouttoMe), .busBtoMe(busBtoMe),
    .stall(stall), .MenouttoMen(MenouttoMen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: derived from the lane/size rules using plain arithmetic.
  function automatic int eff_size(input logic [1:0] sz);
    return (sz >= 2'd2) ? 2 : int'(sz);
  endfunction

  function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
    if (sz == 0) return 4'(1 << (a % 4));
    if (sz == 1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input int sz, input bit sgn, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint unsigned r, v, full;
    int nbytes, off;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    off    = (sz == 0) ? int'(a % 4) : (sz == 1) ? (((a % 4) >= 2) ? 2 : 0) : 0;
    full   = 64'd1 << (8 * nbytes);
    r      = {32'd0, rd};
    v      = (r >> (8 * off)) % full;
    if (sgn && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  function automatic bit exp_misaligned(input int sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHK_EN
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
`else
    return (sz < 0) && (a == 32'd0);  // never true: no alignment check in this build
`endif
  endfunction

  // Runs one access. Call it at posedge+1 with the DUT idle.
  // k is the WAIT-cycle index that gets the ack; k < 0 means no ack is ever sent.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                        input bit sgn, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int k);
    int          es, n_wait;
    bit          st;
    logic [31:0] e_addr, e_wdata, e_load;
    logic [3:0]  e_be;
    es      = eff_size(sz);
    st      = wr;
    e_addr  = (a / 4) * 4;
    e_be    = exp_be(es, a);
    e_wdata = exp_wdata(es, d);
    e_load  = exp_load(es, sgn, a, rdata);
    n_wait  = (k >= 0) ? k + 1 : TMO;

    MemRdtoMe = rd; MemWrtoMe = wr; MemSize = sz; LdSigned = sgn;
    ALUouttoMe = a; busBtoMe = d; mem_ack = 1'b0;
    #1;
    check({tag, ".idle_stall"}, 32'(stall), 32'(1));
    @(posedge clk); #1;
    // Drop the request and scramble the other inputs; the registered copies must hold.
    MemRdtoMe = 1'b0; MemWrtoMe = 1'b0;
    MemSize = 2'($urandom); LdSigned = 1'($urandom);
    ALUouttoMe = $urandom; busBtoMe = $urandom;

    if (exp_misaligned(es, a)) begin
      if (!st) model_out = 32'd0;
      check({tag, ".mis_req"}, 32'(mem_req), 32'(0));
      check({tag, ".mis_stall"}, 32'(stall), 32'(0));
      check({tag, ".align_err"}, 32'(align_err), 32'(1));
      check({tag, ".mis_out"}, MenouttoMen, model_out);
      @(posedge clk); #1;
      check({tag, ".align_clr"}, 32'(align_err), 32'(0));
    end else begin
      for (int i = 0; i < n_wait; i++) begin
        check({tag, ".wait_req"}, 32'(mem_req), 32'(1));
        check({tag, ".wait_stall"}, 32'(stall), 32'(1));
        if (i == 0 || i == n_wait - 1) begin
          check({tag, ".addr"}, mem_addr, e_addr);
          check({tag, ".be"}, 32'(mem_be), 32'(e_be));
          check({tag, ".we"}, 32'(mem_we), 32'(st));
          if (st) check({tag, ".wdata"}, mem_wdata, e_wdata);
        end
        if (i == k) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      if (k < 0) begin
        model_out  = 32'd0;
        model_berr = 1'b1;
      end else if (!st) begin
        model_out = e_load;
      end
      check({tag, ".done_stall"}, 32'(stall), 32'(0));
      check({tag, ".done_req"}, 32'(mem_req), 32'(0));
      check({tag, ".done_out"}, MenouttoMen, model_out);
      check({tag, ".bus_err"}, 32'(bus_err), 32'(model_berr));
      check({tag, ".align_zero"}, 32'(align_err), 32'(0));
      @(posedge clk); #1;
    end
    // Back in IDLE: the output holds, and a stray ack must be ignored.
    check({tag, ".idle_out"}, MenouttoMen, model_out);
    check({tag, ".idle_nostall"}, 32'(stall), 32'(0));
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check({tag, ".stray_req"}, 32'(mem_req), 32'(0));
    check({tag, ".stray_out"}, MenouttoMen, model_out);
    $display("access %s rd=%0b wr=%0b size=%0d addr=%h out=%h bus_err=%0b", tag, rd, wr, sz, a,
             MenouttoMen, bus_err);
  endtask

  initial begin
    rst = 1'b1;
    MemRdtoMe = 1'b0; MemWrtoMe = 1'b0; MemSize = 2'd0; LdSigned = 1'b0;
    ALUouttoMe = 32'd0; busBtoMe = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'(0));
    check("rst.req", 32'(mem_req), 32'(0));
    check("rst.we", 32'(mem_we), 32'(0));
    check("rst.be", 32'(mem_be), 32'(0));
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.out", MenouttoMen, 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'(0));
    check("rst.align_err", 32'(align_err), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed accesses
    access("lw_0x100", 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    access("lb_signed", 1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF_0000, 0);
    access("lb_unsigned", 1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF_0000, 2);
    access("sh_0x12", 0, 1, 2'b01, 0, 32'h12, 32'h1234ABCD, 32'h5555_5555, 0);
    access("rdwr_store", 1, 1, 2'b11, 0, 32'h40, 32'hCAFEF00D, 32'h1111_1111, 3);
    access("lh_hi_signed", 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'h9ABC_1234, 0);
    access("lw_0x102", 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0BAD_F00D, 0);

    // Timeout: with no ack, mem_req stays high for TMO cycles, then bus_err is set.
    access("lw_timeout", 1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0, -1);
    access("lw_after_to", 1, 0, 2'b10, 0, 32'h304, 32'h0, 32'h7654_3210, 0);
    #2 rst = 1'b1;
    #1;
    model_berr = 1'b0;
    model_out  = 32'd0;
    check("to_rst.bus_err", 32'(bus_err), 32'(0));
    check("to_rst.out", MenouttoMen, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Assert reset in the middle of WAIT, then send a late ack after release.
    MemRdtoMe = 1'b1; MemSize = 2'b10; ALUouttoMe = 32'h500;
    @(posedge clk); #1;
    MemRdtoMe = 1'b0;
    @(posedge clk); #1;
    check("midrst.req_before", 32'(mem_req), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst.req", 32'(mem_req), 32'(0));
    check("midrst.stall", 32'(stall), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("midrst.late_req", 32'(mem_req), 32'(0));
    check("midrst.late_stall", 32'(stall), 32'(0));
    check("midrst.late_out", MenouttoMen, 32'd0);
    $display("reset mid-WAIT: req=%0b stall=%0b out=%h", mem_req, stall, MenouttoMen);
    access("lw_after_rst", 1, 0, 2'b10, 0, 32'h600, 32'h0, 32'h0F0F_A5A5, 0);

    // Random accesses
    for (int n = 0; n < 30; n++) begin
      bit rd_r, wr_r;
      rd_r = 1'($urandom);
      wr_r = rd_r ? ($urandom_range(0, 3) == 0) : 1'b1;
      access($sformatf("rand%0d", n), rd_r, wr_r, 2'($urandom), 1'($urandom), $urandom,
             $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
